// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_operand_sequencer_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned REG_CNT_DEF = 8;

  // Bit positions of the ALU flags inside the 4-bit flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReadA = 3'd1,
    StReadB = 3'd2,
    StExec  = 3'd3,
    StWb    = 3'd4
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU operand sequencer: one synchronous write port,
// one combinational read port, register 0 hard-wired to zero.
module alu_regfile #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_CNT = 8,
  localparam int unsigned AW     = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  // Storage: cleared by reset, writes to register 0 dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_CNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read port: register 0 always returns zero.
  always_comb begin
    rdata = '0;
    if (raddr != '0) begin
      rdata = regs_q[raddr];
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequences one instruction at a time through register read, ALU execute and
// write-back. Optional macro ALU_FLAGS_REG_EN adds the registered flag output;
// without it flags_q is tied to zero and no flag storage exists.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_CNT = REG_CNT_DEF,
  localparam int unsigned AW     = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_ctrl,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_ra,
  input  logic [AW-1:0]     instr_rb,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ALU_data_in1,
  output logic [DATA_W-1:0] ALU_data_in2,
  output logic [7:0]        ALU_control,
  input  logic [DATA_W-1:0] ALU_data_out,
  input  logic              N,
  input  logic              Z,
  input  logic              C,
  input  logic              V,
  output logic              alu_valid,
  output logic [3:0]        flags_q,
  output logic              busy
);

  state_e state_q, state_d;

  logic              accept;
  logic              ld_fire;
  logic [7:0]        ctrl_q;
  logic [AW-1:0]     rd_q, ra_q, rb_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [7:0]        alu_ctrl_q;
  logic              alu_valid_q;
  logic [DATA_W-1:0] result_q;

  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [AW-1:0]     rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  // Next state and handshake; a host load in IDLE blocks instruction accept.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    ld_fire     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_en) begin
          ld_fire = 1'b1;
        end else begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            accept  = 1'b1;
            state_d = StReadA;
          end
        end
      end
      StReadA: state_d = use_imm_q ? StExec : StReadB;
      StReadB: state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand latch next values from the single read port.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (state_q == StReadA) begin
      op_a_d = rf_rdata;
      if (use_imm_q) begin
        op_b_d = imm_q;
      end
    end
    if (state_q == StReadB) begin
      op_b_d = rf_rdata;
    end
  end

  // Register file port steering: read port follows the read phase, write port
  // is shared between host preload and write-back (never active together).
  always_comb begin
    rf_raddr = (state_q == StReadA) ? ra_q : rb_q;
    rf_we    = ld_fire || (state_q == StWb);
    rf_waddr = ld_fire ? ld_addr : rd_q;
    rf_wdata = ld_fire ? ld_data : result_q;
  end

  // Sequencer state, latched instruction fields and ALU-facing registers.
  // ALU outputs only change when entering EXEC, so they hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      alu_ctrl_q  <= '0;
      alu_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_valid_q <= (state_d == StExec);
      if (accept) begin
        ctrl_q    <= instr_ctrl;
        rd_q      <= instr_rd;
        ra_q      <= instr_ra;
        rb_q      <= instr_rb;
        use_imm_q <= instr_use_imm;
        imm_q     <= instr_imm;
      end
      if (state_d == StExec) begin
        in1_q      <= op_a_d;
        in2_q      <= op_b_d;
        alu_ctrl_q <= ctrl_q;
      end
      if (state_q == StExec) begin
        result_q <= ALU_data_out;
      end
    end
  end

`ifdef ALU_FLAGS_REG_EN
  logic [3:0] flags_cap_q;
  logic [3:0] flags_out_q;
  logic [3:0] flags_in;

  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_N] = N;
    flags_in[FLAG_Z] = Z;
    flags_in[FLAG_C] = C;
    flags_in[FLAG_V] = V;
  end

  // Flags captured alongside the result in EXEC, published in WB.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_cap_q <= '0;
      flags_out_q <= '0;
    end else begin
      if (state_q == StExec) begin
        flags_cap_q <= flags_in;
      end
      if (state_q == StWb) begin
        flags_out_q <= flags_cap_q;
      end
    end
  end

  assign flags_q = flags_out_q;
`else
  logic unused_flags;
  assign unused_flags = ^{N, Z, C, V};
  assign flags_q      = '0;
`endif

  assign ALU_data_in1 = in1_q;
  assign ALU_data_in2 = in2_q;
  assign ALU_control  = alu_ctrl_q;
  assign alu_valid    = alu_valid_q;
  assign busy         = (state_q != StIdle);

  alu_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
- REQ-001 Parameter DATA_W, default 16: operand/result width.
- REQ-002 Parameter REG_CNT, default 8: register-file depth; address width is clog2(REG_CNT).
- REQ-003 clock  in  1  sole clock; all state updates on rising edge.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 instr_valid  in  1  instruction offered.
- REQ-006 instr_ready  out  1  instruction accepted when valid&ready.
- REQ-007 instr_ctrl  in  8  ALU operation code, passed through unchanged.
- REQ-008 instr_rd / instr_ra / instr_rb  in  3 each  destination / source A / source B register.
- REQ-009 instr_use_imm  in  1  operand B taken from instr_imm instead of rb.
- REQ-010 instr_imm  in  DATA_W  immediate operand.
- REQ-011 ld_en / ld_addr / ld_data  in  1/3/DATA_W  host register preload.
- REQ-012 ALU_data_in1 / ALU_data_in2  out  DATA_W  operands to ALU_16.
- REQ-013 ALU_control  out  8  operation code to ALU_16.
- REQ-014 ALU_data_out  in  DATA_W  ALU result.
- REQ-015 N / Z / C / V  in  1 each  ALU flags.
- REQ-016 alu_valid  out  1  operands and control stable this cycle.
- REQ-017 flags_q  out  4  registered {N,Z,C,V}.
- REQ-018 busy  out  1  FSM not in IDLE.

Function
- REQ-019 FSM states: IDLE, READ_A, READ_B, EXEC, WB.
- REQ-020 IDLE: instr_ready=1; on accept, latch ctrl/rd/ra/rb/use_imm/imm and go to READ_A.
- REQ-021 READ_A: latch reg[ra] into operand A; go to READ_B, or to EXEC with operand B=imm if use_imm.
- REQ-022 READ_B: latch reg[rb] into operand B; go to EXEC.
- REQ-023 EXEC: drive the latched operands and ctrl, alu_valid=1; capture ALU_data_out and N,Z,C,V; go to WB.
- REQ-024 WB: write the captured result to reg[rd] and update flags_q; return to IDLE.
- REQ-025 Latency: accept to write = 4 cycles (3 with use_imm); next instruction accepted the cycle after WB.
- REQ-026 instr_ready=0 in every state other than IDLE.
- REQ-027 Register 0 reads as 0; writes to it are discarded; flags_q still updates.
- REQ-028 ALU outputs hold their last values when alu_valid=0.
- REQ-029 ld_en is honoured only in IDLE and ignored otherwise.
- REQ-030 ld_en and instr_valid in the same IDLE cycle: the load wins and instr_ready=0 that cycle.
- REQ-031 A WB write followed by a read of the same register in the next instruction returns the new value; no forwarding path exists, because the FSM serialises instructions.

Reset
- REQ-032 reset has priority over all inputs, returns the FSM to IDLE, and clears registers, flags_q, latched fields, ALU_data_in1/2, ALU_control and alu_valid to 0.
- REQ-033 reset mid-operation abandons the instruction with no register or flag write; instr_ready=1 the cycle after reset deasserts.

Configuration
- REQ-034 Macro ALU_FLAGS_REG_EN defined: flags_q is registered and updated in WB.
- REQ-035 Macro ALU_FLAGS_REG_EN undefined: no flag storage exists and flags_q is constant 0.

Structure
- REQ-036 A shared package holds the state enum, DATA_W/REG_CNT defaults and the flag bit indices (N=3, Z=2, C=1, V=0).
- REQ-037 Sub-module alu_regfile holds the storage (one sync write port, one comb read port, r0 zero); the FSM lives in the top module.

Verification
- REQ-038 Preload r1=16'h8007, r2=16'hc005; issue ctrl=8'h00, ra=1, rb=2, rd=3; bench ALU returns 16'h8005, NZCV=0000 -> alu_valid exactly one cycle with in1=8007, in2=c005; r3=8005 four cycles after accept.
- REQ-039 use_imm=1, imm=16'h000c, ra=1 with r1=16'h000a, ctrl=8'he6; bench returns 16'h8005, N=1 -> in2=000c; write three cycles after accept; flags_q=4'b1000 (4'b0000 without ALU_FLAGS_REG_EN).
- REQ-040 instr_valid held high through a full instruction -> second accept happens exactly on the cycle after WB; instr_ready=0 in between.
- REQ-041 rd=0, result 16'hffff -> a later read of r0 gives 0.
- REQ-042 reset asserted in READ_B -> the next cycle shows IDLE, instr_ready=1, alu_valid=0, and rd is unchanged.
- REQ-043 ld_en with instr_valid in IDLE -> register loaded, instruction not accepted that cycle, accepted the next cycle.
